// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller for the single-cycle datapath: sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB and strobes every architectural side effect exactly once.
module mc_control_fsm #(
  parameter int unsigned CNT_W       = 32,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             AluSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic [1:0]       Ne,
  output logic             PCWrite,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic op_legal;
  logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_addi;
  logic mem_done;
  logic retire;
  logic sel_en;

  // With waiting disabled the MEM phase always completes in its first cycle.
  assign mem_done = MEM_WAIT_EN ? mem_ready : 1'b1;

  assign is_r    = (op_q == OpR);
  assign is_lw   = (op_q == OpLw);
  assign is_sw   = (op_q == OpSw);
  assign is_beq  = (op_q == OpBeq);
  assign is_bne  = (op_q == OpBne);
  assign is_j    = (op_q == OpJ);
  assign is_addi = (op_q == OpAddi);

  always_comb begin
    op_legal = 1'b0;
    case (OpCode)
      OpR, OpLw, OpSw, OpBeq, OpBne, OpJ, OpAddi: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      op_q     <= 6'd0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state; retire marks the last cycle of an instruction.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    halted_d = halted_q;
    retire   = 1'b0;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        op_d = OpCode;
        if (op_legal) begin
          state_d = StExec;
        end else begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end
      end
      StExec: begin
        if (is_lw || is_sw) begin
          state_d = StMem;
        end else if (is_r || is_addi) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
          retire  = is_beq || is_bne || is_j;
        end
      end
      StMem: begin
        if (mem_done) begin
          if (is_lw) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // Moore decode of {state, op_q}; only sw's MemWrite/PCWrite look at mem_ready.
  always_comb begin
    RegDst   = 1'b0;
    AluSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    Ne       = 2'b00;
    sel_en   = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);
    if (sel_en) begin
      case (op_q)
        OpR: begin
          RegDst = 1'b1;
          ALUOp  = 2'b10;
        end
        OpAddi, OpSw: AluSrc = 1'b1;
        OpLw: begin
          AluSrc   = 1'b1;
          MemtoReg = 1'b1;
        end
        OpBeq: ALUOp = 2'b01;
        OpBne: begin
          ALUOp = 2'b01;
          Ne    = 2'b01;
        end
        OpJ:     Ne = 2'b10;
        default: ;
      endcase
    end
    RegWrite = (state_q == StWb);
    MemRead  = is_lw && ((state_q == StMem) || (state_q == StWb));
    MemWrite = is_sw && (state_q == StMem) && mem_done;
    Branch   = (state_q == StExec) && (is_beq || is_bne);
  end

  assign PCWrite     = retire;
  assign halted      = halted_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle vector table plus reset, halt, wrap and
// no-wait corner sequences. Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mc_control_fsm;

  localparam int unsigned CW = 4;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JUNK = 6'b110011;
  localparam logic [5:0] ILL  = 6'b111111;

  // {RegDst,AluSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,Ne,PCWrite}
  localparam logic [11:0] NONE    = 12'b0_0_0_0_0_0_0_00_00_0;
  localparam logic [11:0] R_EX    = 12'b1_0_0_0_0_0_0_10_00_0;
  localparam logic [11:0] R_WB    = 12'b1_0_0_1_0_0_0_10_00_1;
  localparam logic [11:0] LW_EX   = 12'b0_1_1_0_0_0_0_00_00_0;
  localparam logic [11:0] LW_MEM  = 12'b0_1_1_0_1_0_0_00_00_0;
  localparam logic [11:0] LW_WB   = 12'b0_1_1_1_1_0_0_00_00_1;
  localparam logic [11:0] SW_EX   = 12'b0_1_0_0_0_0_0_00_00_0;
  localparam logic [11:0] SW_MD   = 12'b0_1_0_0_0_1_0_00_00_1;
  localparam logic [11:0] BEQ_EX  = 12'b0_0_0_0_0_0_1_01_00_1;
  localparam logic [11:0] BNE_EX  = 12'b0_0_0_0_0_0_1_01_01_1;
  localparam logic [11:0] J_EX    = 12'b0_0_0_0_0_0_0_00_10_1;
  localparam logic [11:0] ADDI_EX = 12'b0_1_0_0_0_0_0_00_00_0;
  localparam logic [11:0] ADDI_WB = 12'b0_1_0_1_0_0_0_00_00_1;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [2:0]  st;
    logic [11:0] ctrl;
    logic [3:0]  cnt;
    logic        hlt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    OpCode;
  logic          mem_ready;
  logic          RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite;
  logic [1:0]    ALUOp, Ne;
  logic          halted;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;
  logic [11:0]   ctrl;

  logic          nw_RegDst, nw_AluSrc, nw_MemtoReg, nw_RegWrite, nw_MemRead, nw_MemWrite;
  logic          nw_Branch, nw_PCWrite, nw_halted;
  logic [1:0]    nw_ALUOp, nw_Ne;
  logic [2:0]    nw_state;
  logic [CW-1:0] nw_instr_count;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  assign ctrl = {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Ne,
                 PCWrite};

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(CW), .MEM_WAIT_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
    .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .Ne(Ne),
    .PCWrite(PCWrite), .halted(halted), .state(state), .instr_count(instr_count)
  );

  mc_control_fsm #(.CNT_W(CW), .MEM_WAIT_EN(1'b0)) u_dut_nw (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
    .RegDst(nw_RegDst), .AluSrc(nw_AluSrc), .MemtoReg(nw_MemtoReg), .RegWrite(nw_RegWrite),
    .MemRead(nw_MemRead), .MemWrite(nw_MemWrite), .Branch(nw_Branch), .ALUOp(nw_ALUOp),
    .Ne(nw_Ne), .PCWrite(nw_PCWrite), .halted(nw_halted), .state(nw_state),
    .instr_count(nw_instr_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [2:0] st,
                     input logic [11:0] c, input logic [3:0] n, input logic h);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.ctrl = c; v.cnt = n; v.hlt = h;
    vecs.push_back(v);
  endtask

  // Asynchronous reset pulse placed mid-cycle, released on the next falling edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, ".rst_state"}, 32'(state), 32'd0);
    chk({tag, ".rst_ctrl"}, 32'(ctrl), 32'(NONE));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] nw_ops [6];
    logic [2:0] nw_st  [6];
    logic [2:0] mn_st  [6];
    logic       nw_rw  [6];
    int         rw_pulses;

    // R, R, lw with 3 wait cycles, sw, sw with 1 wait, beq, bne, j, addi, illegal
    add(JUNK, 0, 0, NONE,    0, 0); add(R,    0, 1, NONE,    0, 0);
    add(ILL,  0, 2, R_EX,    0, 0); add(JUNK, 1, 4, R_WB,    0, 0);
    add(JUNK, 0, 0, NONE,    1, 0); add(R,    1, 1, NONE,    1, 0);
    add(JMP,  0, 2, R_EX,    1, 0); add(JMP,  0, 4, R_WB,    1, 0);
    add(JUNK, 0, 0, NONE,    2, 0); add(LW,   0, 1, NONE,    2, 0);
    add(JMP,  1, 2, LW_EX,   2, 0); add(LW,   0, 3, LW_MEM,  2, 0);
    add(SW,   0, 3, LW_MEM,  2, 0); add(LW,   0, 3, LW_MEM,  2, 0);
    add(LW,   1, 3, LW_MEM,  2, 0); add(JUNK, 0, 4, LW_WB,   2, 0);
    add(JUNK, 1, 0, NONE,    3, 0); add(SW,   1, 1, NONE,    3, 0);
    add(SW,   1, 2, SW_EX,   3, 0); add(SW,   1, 3, SW_MD,   3, 0);
    add(R,    0, 0, NONE,    4, 0); add(SW,   0, 1, NONE,    4, 0);
    add(SW,   0, 2, SW_EX,   4, 0); add(SW,   0, 3, SW_EX,   4, 0);
    add(SW,   1, 3, SW_MD,   4, 0);
    add(JUNK, 0, 0, NONE,    5, 0); add(BEQ,  0, 1, NONE,    5, 0);
    add(JUNK, 0, 2, BEQ_EX,  5, 0);
    add(JUNK, 0, 0, NONE,    6, 0); add(BNE,  0, 1, NONE,    6, 0);
    add(BEQ,  0, 2, BNE_EX,  6, 0);
    add(JUNK, 0, 0, NONE,    7, 0); add(JMP,  0, 1, NONE,    7, 0);
    add(R,    0, 2, J_EX,    7, 0);
    add(JUNK, 0, 0, NONE,    8, 0); add(ADDI, 0, 1, NONE,    8, 0);
    add(ADDI, 0, 2, ADDI_EX, 8, 0); add(JUNK, 0, 4, ADDI_WB, 8, 0);
    add(JUNK, 0, 0, NONE,    9, 0); add(ILL,  0, 1, NONE,    9, 0);
    add(R,    0, 5, NONE,    9, 1); add(LW,   1, 5, NONE,    9, 1);

    reset = 1'b0;
    OpCode = 6'd0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.ctrl", 32'(ctrl), 32'(NONE));
    chk("reset.count", 32'(instr_count), 32'd0);
    chk("reset.halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      OpCode = vecs[i].op;
      mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("vec[%0d].state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec[%0d].ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("vec[%0d].count", i), 32'(instr_count), 32'(vecs[i].cnt));
      chk($sformatf("vec[%0d].halted", i), 32'(halted), 32'(vecs[i].hlt));
      chk($sformatf("vec[%0d].rd_wr_excl", i), 32'(MemRead & MemWrite), 32'd0);
      @(negedge clk);
    end

    // HALT absorbs any opcode
    for (int i = 0; i < 20; i++) begin
      OpCode = 6'($urandom);
      mem_ready = 1'($urandom);
      #1;
      chk($sformatf("halt[%0d].state", i), 32'(state), 32'd5);
      chk($sformatf("halt[%0d].ctrl", i), 32'(ctrl), 32'(NONE));
      chk($sformatf("halt[%0d].halted", i), 32'(halted), 32'd1);
      chk($sformatf("halt[%0d].count", i), 32'(instr_count), 32'd9);
      @(negedge clk);
    end
    pulse_reset("halt_exit");
    #1;
    chk("halt_exit.halted", 32'(halted), 32'd0);
    chk("halt_exit.count", 32'(instr_count), 32'd0);

    // lw with mem_ready low: no-wait instance completes, waiting instance holds in MEM
    nw_ops = '{JUNK, LW, JUNK, JUNK, JUNK, JUNK};
    nw_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    mn_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
    nw_rw  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      OpCode = nw_ops[i];
      mem_ready = 1'b0;
      #1;
      chk($sformatf("nowait[%0d].state", i), 32'(nw_state), 32'(nw_st[i]));
      chk($sformatf("nowait[%0d].regwrite", i), 32'(nw_RegWrite), 32'(nw_rw[i]));
      chk($sformatf("nowait[%0d].wait_state", i), 32'(state), 32'(mn_st[i]));
      @(negedge clk);
    end
    chk("nowait.count", 32'(nw_instr_count), 32'd1);
    pulse_reset("nowait_exit");

    // 17 back-to-back jumps: counter wraps 15 -> 0 -> 1
    for (int k = 1; k <= 17; k++) begin
      OpCode = JMP;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("jwrap[%0d].pcwrite", k), 32'(PCWrite), 32'd1);
      chk($sformatf("jwrap[%0d].ne", k), 32'(Ne), 32'd2);
      @(negedge clk);
      #1;
      chk($sformatf("jwrap[%0d].count", k), 32'(instr_count), 32'(k % 16));
      #0;
    end

    // Reset while lw waits in MEM: the load's register write never happens
    pulse_reset("lw_abort_pre");
    OpCode = LW;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("lw_abort.in_mem", 32'(state), 32'd3);
    chk("lw_abort.memread", 32'(MemRead), 32'd1);
    pulse_reset("lw_abort");
    OpCode = JMP;
    mem_ready = 1'b1;
    rw_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (RegWrite) rw_pulses++;
      @(negedge clk);
    end
    chk("lw_abort.regwrite_pulses", 32'(rw_pulses), 32'd0);
    chk("lw_abort.count", 32'(instr_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller placed directly upstream of the single-cycle datapath.
- Takes the datapath's OpCode output and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB phases.
- Drives every datapath control input (RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Ne) plus a PC write strobe.
- Architectural side effects (register write, memory write, PC update) happen exactly once per instruction. Adds a data-memory ready handshake, illegal-opcode halt and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_WAIT_EN, 1, 1 = MEM state honours mem_ready; 0 = mem_ready treated as constantly 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
OpCode  input  6  Instruction[31:26] from datapath
mem_ready  input  1  data memory access complete (sampled in MEM only)
RegDst  output  1  write-register select (1 = rd)
AluSrc  output  1  ALU B select (1 = sign-extended immediate)
MemtoReg  output  1  writeback select (1 = ReadData)
RegWrite  output  1  register file write enable
MemRead  output  1  data memory read enable
MemWrite  output  1  data memory write enable
Branch  output  1  branch qualify
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
Ne  output  2  [0] = branch on not-zero, [1] = select jump address
PCWrite  output  1  one-cycle PC update strobe
halted  output  1  illegal opcode seen; sticky until reset
state  output  3  current state encoding (debug)
instr_count  output  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (reset=0, async):
  - state=FETCH; op_q=0; instr_count=0; halted=0.
  - All control outputs 0; PCWrite=0.
  - Release is synchronous to the next clk edge.
- FETCH:
  - All enables 0.
  - Next state: DECODE.
- DECODE:
  - Latch op_q <= OpCode.
  - Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, addi=001000.
  - Any other opcode -> HALT. Otherwise -> EXEC.
- Steady decode values:
  - Outputs are Moore-decoded from {state, op_q}.
  - Mux selects (RegDst, AluSrc, MemtoReg, ALUOp, Ne) hold their decoded value from EXEC through the last state of the instruction; they are 0 in FETCH, DECODE and HALT.
- Per-opcode selects:
  - R: RegDst=1, ALUOp=10.
  - addi: AluSrc=1, ALUOp=00.
  - lw: AluSrc=1, MemtoReg=1, ALUOp=00.
  - sw: AluSrc=1, ALUOp=00.
  - beq: ALUOp=01, Ne=00.
  - bne: ALUOp=01, Ne=01.
  - j: Ne=10.
- State paths and final cycle:
  - R/addi: EXEC -> WB. RegWrite=1 and PCWrite=1 in WB only. 4 cycles.
  - lw: EXEC -> MEM -> WB.
    - MemRead=1 throughout MEM and WB.
    - MEM holds while mem_ready=0.
    - WB asserts RegWrite=1 and PCWrite=1.
    - 5 cycles minimum.
  - sw: EXEC -> MEM.
    - MemWrite=1 only in the MEM cycle where mem_ready=1; MemWrite=0 while waiting.
    - PCWrite=1 in the same cycle.
    - 4 cycles minimum.
  - beq/bne/j: EXEC only. Branch=1 (beq/bne) and PCWrite=1 in EXEC. 3 cycles.
- Retirement:
  - The final cycle of each instruction returns to FETCH.
  - instr_count increments on the same edge, wrapping 2^CNT_W-1 -> 0.
- HALT:
  - All enables 0; halted=1.
  - Absorbing state; instr_count frozen; OpCode ignored.
  - Exit only via reset.
- Invariants:
  - RegWrite, MemWrite and PCWrite are each asserted for at most one cycle per instruction.
  - MemRead and MemWrite are never both 1.
  - OpCode changes outside DECODE have no effect.
- Reset mid-instruction: immediate return to FETCH with all enables 0; the in-flight instruction's write never occurs.
- MEM_WAIT_EN=0: MEM always completes in one cycle.

Test Plan:
- Reset, then release with OpCode=000000 -> states 0,1,2,4 repeating; RegDst=1, ALUOp=10 in EXEC/WB; RegWrite=PCWrite=1 only in WB; instr_count=1 after first WB edge.
- OpCode=100011, mem_ready held 0 for 3 cycles then 1 -> MEM lasts 4 cycles with MemRead=1, MemtoReg=1; WB then RegWrite=1, PCWrite=1; 8 cycles total.
- OpCode=101011, mem_ready=1 -> MemWrite=1 and PCWrite=1 in the single MEM cycle; RegWrite never 1; 4 cycles.
- OpCode=000101 then 000010 -> bne: Ne=01, Branch=1, ALUOp=01, PCWrite=1 in EXEC (3 cycles); j: Ne=10, Branch=0, PCWrite=1 in EXEC.
- OpCode=111111 -> DECODE -> HALT; halted=1, all enables 0 for 20 cycles under any OpCode; reset pulse low -> state=0, halted=0.
- CNT_W=4, 17 back-to-back j instructions -> instr_count wraps 15 -> 0 -> 1; reset asserted during lw MEM -> no RegWrite pulse and state=0 asynchronously.
